// File: rtl/mem_stage_if.sv
// Data-bus handshake between the memory stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        dreq_valid;
  logic        dreq_write;
  logic [63:0] dreq_addr;
  logic [63:0] dreq_wdata;
  logic [7:0]  dreq_strb;
  logic        dresp_ok;
  logic [63:0] dresp_data;

  modport master (
    output dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_strb,
    input  dresp_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_strb,
    output dresp_ok, dresp_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory/writeback stage: latches execute results, runs the data-bus access and
// emits a one-cycle writeback pulse.
//   state  | meaning
//   S_IDLE | waiting for exu_finish
//   S_REQ  | bus request outstanding, timeout running
//   S_DONE | wb_valid pulse
module mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exu_finish,
  input  logic [63:0] alu_out,
  input  logic [63:0] br_out,
  input  logic [63:0] div_out,
  input  logic [63:0] rem_out,
  input  logic [63:0] mul_out,
  input  logic [63:0] store_data,
  input  logic [2:0]  wb_sel,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsign,
  mem_stage_if.master bus,
  output logic        busy,
  output logic        wb_valid,
  output logic [63:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_next;
  logic [63:0]   r_alu, r_br, r_div, r_rem, r_mul, r_sd, r_rdata;
  logic [2:0]    r_sel;
  logic [1:0]    r_size;
  logic          r_write, r_unsign, r_mis, r_berr;
  logic          is_mem, mis_in, in_req, in_done;

  assign is_mem   = mem_read | mem_write;
  assign tmo_next = tmo_cnt + TW'(1);

  always_comb begin
    case (mem_size)
      2'd1:    mis_in = alu_out[0];
      2'd2:    mis_in = |alu_out[1:0];
      2'd3:    mis_in = |alu_out[2:0];
      default: mis_in = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tmo_cnt  <= '0;
      r_alu    <= '0;
      r_br     <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_mul    <= '0;
      r_sd     <= '0;
      r_rdata  <= '0;
      r_sel    <= '0;
      r_size   <= '0;
      r_write  <= 1'b0;
      r_unsign <= 1'b0;
      r_mis    <= 1'b0;
      r_berr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (exu_finish) begin
            r_alu    <= alu_out;
            r_br     <= br_out;
            r_div    <= div_out;
            r_rem    <= rem_out;
            r_mul    <= mul_out;
            r_sd     <= store_data;
            r_sel    <= wb_sel;
            r_size   <= mem_size;
            r_write  <= mem_write & ~mem_read;
            r_unsign <= mem_unsign;
            r_mis    <= is_mem & mis_in;
            r_berr   <= 1'b0;
            r_rdata  <= '0;
            tmo_cnt  <= '0;
            state    <= (is_mem && !mis_in) ? S_REQ : S_DONE;
          end
        end
        S_REQ: begin
          // A response in the same cycle the counter expires takes priority.
          if (bus.dresp_ok) begin
            r_rdata <= bus.dresp_data;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_next;
            if (tmo_next == TW'(TIMEOUT)) begin
              r_berr <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_req  = (state == S_REQ);
  assign in_done = (state == S_DONE);

  logic [7:0]  strb_base;
  logic [63:0] wdata_rep;
  always_comb begin
    case (r_size)
      2'd0: begin strb_base = 8'h01; wdata_rep = {8{r_sd[7:0]}};  end
      2'd1: begin strb_base = 8'h03; wdata_rep = {4{r_sd[15:0]}}; end
      2'd2: begin strb_base = 8'h0F; wdata_rep = {2{r_sd[31:0]}}; end
      default: begin strb_base = 8'hFF; wdata_rep = r_sd; end
    endcase
  end

  assign bus.dreq_valid = in_req;
  assign bus.dreq_write = in_req & r_write;
  assign bus.dreq_addr  = in_req ? {r_alu[63:3], 3'b000} : 64'd0;
  assign bus.dreq_wdata = in_req ? wdata_rep : 64'd0;
  assign bus.dreq_strb  = in_req ? (strb_base << r_alu[2:0]) : 8'h00;

  logic [63:0] lane, load_val, src;
  assign lane = r_rdata >> {r_alu[2:0], 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    load_val = r_unsign ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'd1:    load_val = r_unsign ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2:    load_val = r_unsign ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    case (r_sel)
      3'd1:    src = r_br;
      3'd2:    src = r_div;
      3'd3:    src = r_rem;
      3'd4:    src = r_mul;
      3'd5:    src = load_val;
      default: src = r_alu;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign wb_valid = in_done;
  assign misalign = in_done & r_mis;
  assign bus_err  = in_done & r_berr;
  assign wb_data  = (in_done && !r_mis && !r_berr) ? src : 64'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4; expected values are hand-computed.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exu_finish = 1'b0;
  logic [63:0] alu_out = '0, br_out = '0, div_out = '0, rem_out = '0, mul_out = '0, store_data = '0;
  logic [2:0]  wb_sel = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsign = 1'b0;
  logic [1:0]  mem_size = '0;
  logic        busy, wb_valid, misalign, bus_err;
  logic [63:0] wb_data;

  int n_vec = 0;
  int n_mis = 0;

  mem_stage_if bus_i ();

  mem_stage #(.TIMEOUT(4), .TW(3)) dut (
    .clk(clk), .rst(rst), .exu_finish(exu_finish),
    .alu_out(alu_out), .br_out(br_out), .div_out(div_out), .rem_out(rem_out),
    .mul_out(mul_out), .store_data(store_data), .wb_sel(wb_sel),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsign(mem_unsign), .bus(bus_i), .busy(busy), .wb_valid(wb_valid),
    .wb_data(wb_data), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [63:0] a, input logic [2:0] sel, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic uns);
    alu_out = a; wb_sel = sel; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsign = uns;
  endtask

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic pulse_finish();
    exu_finish = 1'b1;
    @(negedge clk);
    exu_finish = 1'b0;
  endtask

  task automatic chk_req(input string tag, input logic wr, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [7:0] strb);
    chk({tag, "_valid"}, {63'd0, bus_i.dreq_valid}, 64'd1);
    chk({tag, "_write"}, {63'd0, bus_i.dreq_write}, {63'd0, wr});
    chk({tag, "_addr"},  bus_i.dreq_addr, addr);
    if (wr) chk({tag, "_wdata"}, bus_i.dreq_wdata, wd);
    chk({tag, "_strb"},  {56'd0, bus_i.dreq_strb}, {56'd0, strb});
  endtask

  // Runs a bus access already in REQ: n_wait cycles without dresp_ok, then one with it.
  task automatic bus_access(input string tag, input int n_wait, input logic wr,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic [7:0] strb, input logic [63:0] rdata,
                            input logic [63:0] exp_wb);
    for (int i = 0; i <= n_wait; i++) begin
      chk_req(tag, wr, addr, wd, strb);
      if (i == n_wait) begin
        bus_i.dresp_ok = 1'b1;
        bus_i.dresp_data = rdata;
      end
      @(negedge clk);
      bus_i.dresp_ok = 1'b0;
      bus_i.dresp_data = '0;
    end
    chk({tag, "_wbv"},  {63'd0, wb_valid}, 64'd1);
    chk({tag, "_wbd"},  wb_data, exp_wb);
    chk({tag, "_err"},  {62'd0, misalign, bus_err}, 64'd0);
    chk({tag, "_drop"}, {63'd0, bus_i.dreq_valid}, 64'd0);
    @(negedge clk);
    chk({tag, "_wbv0"}, {63'd0, wb_valid}, 64'd0);
  endtask

  int cnt, seen;
  logic errv;
  logic [63:0] dv;

  initial begin
    bus_i.dresp_ok = 1'b0;
    bus_i.dresp_data = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wbv",  {63'd0, wb_valid}, 64'd0);
    chk("rst_dv",   {63'd0, bus_i.dreq_valid}, 64'd0);
    chk("rst_wbd",  wb_data, 64'd0);
    chk("rst_strb", {56'd0, bus_i.dreq_strb}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // ALU and MUL writebacks
    set_op(64'h1234, 3'd0, 0, 0, 2'd0, 0);
    pulse_finish();
    chk("alu_wbv", {63'd0, wb_valid}, 64'd1);
    chk("alu_wbd", wb_data, 64'h1234);
    chk("alu_dv",  {63'd0, bus_i.dreq_valid}, 64'd0);
    chk("alu_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("alu_wbv0", {63'd0, wb_valid}, 64'd0);
    mul_out = 64'hABCD;
    set_op(64'h9999, 3'd4, 0, 0, 2'd0, 0);
    pulse_finish();
    chk("mul_wbd", wb_data, 64'hABCD);
    @(negedge clk);

    // Signed / unsigned byte loads at offset 3
    set_op(64'h1003, 3'd5, 1, 0, 2'd0, 0);
    pulse_finish();
    bus_access("lbs", 2, 0, 64'h1000, 64'd0, 8'h08, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
    set_op(64'h1003, 3'd5, 1, 0, 2'd0, 1);
    pulse_finish();
    bus_access("lbu", 2, 0, 64'h1000, 64'd0, 8'h08, 64'h00000000_80000000, 64'h80);

    // Signed half load at offset 6
    set_op(64'h5006, 3'd5, 1, 0, 2'd1, 0);
    pulse_finish();
    bus_access("lhs", 0, 0, 64'h5000, 64'd0, 8'hC0, 64'h8001_0000_0000_0000, 64'hFFFFFFFF_FFFF8001);

    // Half store at offset 6; writeback is the ALU value
    store_data = 64'hBEEF;
    set_op(64'h2006, 3'd0, 0, 1, 2'd1, 0);
    pulse_finish();
    bus_access("sh", 1, 1, 64'h2000, 64'hBEEFBEEF_BEEFBEEF, 8'hC0, 64'd0, 64'h2006);

    // Word store at offset 4
    store_data = 64'h1111_2222_DEAD_BEEF;
    set_op(64'h6004, 3'd0, 0, 1, 2'd2, 0);
    pulse_finish();
    bus_access("sw", 0, 1, 64'h6000, 64'hDEADBEEF_DEADBEEF, 8'hF0, 64'd0, 64'h6004);

    // Read and write together: load wins
    set_op(64'h10, 3'd5, 1, 1, 2'd3, 0);
    pulse_finish();
    bus_access("rdwr", 0, 0, 64'h10, 64'd0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // Misaligned word load
    set_op(64'h3002, 3'd5, 1, 0, 2'd2, 0);
    pulse_finish();
    chk("mis_dv",  {63'd0, bus_i.dreq_valid}, 64'd0);
    chk("mis_wbv", {63'd0, wb_valid}, 64'd1);
    chk("mis_flag", {63'd0, misalign}, 64'd1);
    chk("mis_wbd", wb_data, 64'd0);
    @(negedge clk);
    chk("mis_flag0", {63'd0, misalign}, 64'd0);

    // Timeout with no response
    set_op(64'h4000, 3'd5, 1, 0, 2'd3, 0);
    pulse_finish();
    cnt = 0; seen = 0; errv = 0; dv = '1;
    for (int i = 0; i < 10; i++) begin
      if (bus_i.dreq_valid) cnt++;
      if (wb_valid) begin seen++; errv = bus_err; dv = wb_data; end
      @(negedge clk);
    end
    chk("tmo_cycles", 64'(cnt), 64'd4);
    chk("tmo_wbs",    64'(seen), 64'd1);
    chk("tmo_err",    {63'd0, errv}, 64'd1);
    chk("tmo_wbd",    dv, 64'd0);

    // Response in the cycle the counter expires wins
    set_op(64'h4000, 3'd5, 1, 0, 2'd3, 0);
    pulse_finish();
    cnt = 0; seen = 0; errv = 1; dv = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus_i.dreq_valid) cnt++;
      if (wb_valid) begin seen++; errv = bus_err; dv = wb_data; end
      bus_i.dresp_ok = bus_i.dreq_valid && (cnt == 4);
      bus_i.dresp_data = 64'h1122_3344_5566_7788;
      @(negedge clk);
    end
    bus_i.dresp_ok = 1'b0;
    chk("tmo4_cycles", 64'(cnt), 64'd4);
    chk("tmo4_wbs",    64'(seen), 64'd1);
    chk("tmo4_err",    {63'd0, errv}, 64'd0);
    chk("tmo4_wbd",    dv, 64'h1122_3344_5566_7788);

    // Reset mid-REQ
    set_op(64'h7000, 3'd5, 1, 0, 2'd3, 0);
    pulse_finish();
    chk("rreq_dv", {63'd0, bus_i.dreq_valid}, 64'd1);
    rst = 1'b0;
    #1;
    chk("rreq_dv0",   {63'd0, bus_i.dreq_valid}, 64'd0);
    chk("rreq_busy0", {63'd0, busy}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (wb_valid || bus_i.dreq_valid) seen++;
      @(negedge clk);
    end
    chk("rreq_none", 64'(seen), 64'd0);

    // exu_finish while busy is ignored
    set_op(64'h8004, 3'd5, 1, 0, 2'd2, 1);
    pulse_finish();
    set_op(64'h5555, 3'd0, 0, 0, 2'd0, 0);
    exu_finish = 1'b1;
    @(negedge clk);
    exu_finish = 1'b0;
    chk("ign_addr", bus_i.dreq_addr, 64'h8000);
    seen = 0; dv = '0;
    for (int i = 0; i < 8; i++) begin
      bus_i.dresp_ok = (i == 1);
      bus_i.dresp_data = 64'hCAFE_F00D_0000_0000;
      if (wb_valid) begin seen++; dv = wb_data; end
      @(negedge clk);
    end
    bus_i.dresp_ok = 1'b0;
    chk("ign_wbs", 64'(seen), 64'd1);
    chk("ign_wbd", dv, 64'h0000_0000_CAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
